// File: rtl/raise_sched_if.sv
// Bin-pair input, engine handshake and output-bin bus of raise_sched.
interface raise_sched_if;
    logic        fft1_valid;
    logic [31:0] fft1_data;
    logic [5:0]  freq1;
    logic        fft2_valid;
    logic [31:0] fft2_data;
    logic [5:0]  freq2;
    logic        fft_ready;
    logic        eng_start;
    logic [31:0] eng_data1;
    logic [31:0] eng_data2;
    logic [5:0]  eng_freq;
    logic        eng_done;
    logic [31:0] eng_result;
    logic        raise_valid;
    logic [31:0] raise_data;
    logic [5:0]  freq_out;
    logic        raise_fin;
    logic [7:0]  frame_cnt;
    logic        err_mismatch;
    logic        err_timeout;

    modport slave (
        input  fft1_valid, fft1_data, freq1, fft2_valid, fft2_data, freq2,
               eng_done, eng_result,
        output fft_ready, eng_start, eng_data1, eng_data2, eng_freq,
               raise_valid, raise_data, freq_out, raise_fin, frame_cnt,
               err_mismatch, err_timeout
    );

    modport master (
        output fft1_valid, fft1_data, freq1, fft2_valid, fft2_data, freq2,
               eng_done, eng_result,
        input  fft_ready, eng_start, eng_data1, eng_data2, eng_freq,
               raise_valid, raise_data, freq_out, raise_fin, frame_cnt,
               err_mismatch, err_timeout
    );
endinterface

// File: rtl/raise_sched.sv
// Queues FFT bin pairs and feeds them one at a time to the pitch-raise engine.
// state | meaning: IDLE wait for queued pair | ISSUE pop head, start engine | WAIT engine busy, timer runs | OUT output bin pulse
module raise_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         rst,
    raise_sched_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;
    state_t state_q, state_d;

    logic [69:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          eng_start_q, eng_start_d;
    logic [31:0]   eng_data1_q, eng_data1_d;
    logic [31:0]   eng_data2_q, eng_data2_d;
    logic [31:0]   raise_data_q, raise_data_d;
    logic [5:0]    eng_freq_q, eng_freq_d;
    logic [5:0]    freq_out_q, freq_out_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          err_mis_q, err_mis_d;
    logic          err_to_q, err_to_d;
    logic          ready, push, pop, timed_out;
    logic [69:0]   head;

    assign ready     = (count_q != FULL);
    assign push      = bus.fft1_valid & bus.fft2_valid & ready;
    assign head      = mem_q[rd_ptr_q];
    assign timed_out = (timer_q == TLIM);
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign err_mis_d = err_mis_q | (push & (bus.freq1 != bus.freq2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (bus.eng_done || timed_out) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // eng_done takes priority over the timeout when both land in the same WAIT cycle.
    always_comb begin
        pop          = 1'b0;
        eng_start_d  = 1'b0;
        eng_data1_d  = eng_data1_q;
        eng_data2_d  = eng_data2_q;
        eng_freq_d   = eng_freq_q;
        timer_d      = timer_q;
        raise_data_d = raise_data_q;
        freq_out_d   = freq_out_q;
        err_to_d     = err_to_q;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            S_ISSUE: begin
                pop         = 1'b1;
                eng_start_d = 1'b1;
                {eng_data1_d, eng_data2_d, eng_freq_d} = head;
                timer_d     = '0;
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    raise_data_d = bus.eng_result;
                    freq_out_d   = eng_freq_q;
                end else if (timed_out) begin
                    raise_data_d = '0;
                    freq_out_d   = eng_freq_q;
                    err_to_d     = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OUT: if (freq_out_q == 6'd63) frame_cnt_d = frame_cnt_q + 8'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.fft1_data, bus.fft2_data, bus.freq1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            eng_start_q  <= 1'b0;
            eng_data1_q  <= '0;
            eng_data2_q  <= '0;
            eng_freq_q   <= '0;
            raise_data_q <= '0;
            freq_out_q   <= '0;
            frame_cnt_q  <= '0;
            err_mis_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q      <= count_d;
            timer_q      <= timer_d;
            eng_start_q  <= eng_start_d;
            eng_data1_q  <= eng_data1_d;
            eng_data2_q  <= eng_data2_d;
            eng_freq_q   <= eng_freq_d;
            raise_data_q <= raise_data_d;
            freq_out_q   <= freq_out_d;
            frame_cnt_q  <= frame_cnt_d;
            err_mis_q    <= err_mis_d;
            err_to_q     <= err_to_d;
        end
    end

    assign bus.fft_ready    = ready;
    assign bus.eng_start    = eng_start_q;
    assign bus.eng_data1    = eng_data1_q;
    assign bus.eng_data2    = eng_data2_q;
    assign bus.eng_freq     = eng_freq_q;
    assign bus.raise_valid  = (state_q == S_OUT);
    assign bus.raise_data   = raise_data_q;
    assign bus.freq_out     = freq_out_q;
    assign bus.raise_fin    = (state_q == S_OUT) && (freq_out_q == 6'd63);
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.err_mismatch = err_mis_q;
    assign bus.err_timeout  = err_to_q;
endmodule

// File: doc/raise_sched.md
RAISE_SCHED -- requirements
Module: raise_sched

Interface
- REQ-001: Parameter DEPTH, default 4; number of entries in the bin-pair FIFO (power of two, 2..16).
- REQ-002: Parameter TIMEOUT, default 31; maximum cycles spent waiting for eng_done before the result is abandoned.
- REQ-003: The block SHALL use one clock and an asynchronous, active-low reset.
- REQ-004: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-005: rst  in  1  asynchronous, active-low reset.
- REQ-006: fft1_valid  in  1  bin from FFT 1 is present.
- REQ-007: fft1_data  in  32  FFT 1 bin, {real[31:16], imag[15:0]}, signed.
- REQ-008: freq1  in  6  bin index of fft1_data.
- REQ-009: fft2_valid, fft2_data, freq2  in  1/32/6  same as above, for FFT 2.
- REQ-010: fft_ready  out  1  FIFO can accept a bin pair.
- REQ-011: eng_start  out  1  one-cycle start pulse to the pitch-raise engine.
- REQ-012: eng_data1, eng_data2  out  32  operands for the engine, held stable from eng_start until the job completes.
- REQ-013: eng_freq  out  6  bin index of the issued job.
- REQ-014: eng_done  in  1  engine result is valid; sampled only in WAIT.
- REQ-015: eng_result  in  32  engine output, {real, imag}.
- REQ-016: raise_valid  out  1  one-cycle pulse marking a valid output bin.
- REQ-017: raise_data  out  32  output bin data.
- REQ-018: freq_out  out  6  output bin index.
- REQ-019: raise_fin  out  1  high together with raise_valid when freq_out == 63.
- REQ-020: frame_cnt  out  8  count of completed frames.
- REQ-021: err_mismatch, err_timeout  out  1  sticky error flags.

Function
- REQ-022: fft_ready SHALL equal (FIFO count < DEPTH), decoded from registered state only.
- REQ-023: A push SHALL occur when fft1_valid & fft2_valid & fft_ready are all high, storing {fft1_data, fft2_data, freq1}.
- REQ-024: If exactly one of fft1_valid/fft2_valid is high, nothing SHALL be pushed and no state SHALL change.
- REQ-025: On a push with freq1 != freq2, err_mismatch SHALL set and stay set; the entry is still pushed using freq1.
- REQ-026: A push and a pop in the same cycle SHALL leave the count unchanged. Read and write pointers wrap modulo DEPTH.
- REQ-027: The FSM SHALL have the states IDLE, ISSUE, WAIT and OUT.
- REQ-028: IDLE -> ISSUE when the registered count is > 0; otherwise stay in IDLE.
- REQ-029: In ISSUE, the block SHALL:
  - register the FIFO head onto eng_data1, eng_data2 and eng_freq;
  - pop the FIFO;
  - clear the wait timer;
  - assert eng_start for exactly that cycle (eng_data is valid from the same cycle);
  - then go to WAIT.
- REQ-030: In WAIT with eng_done high, the block SHALL set raise_data = eng_result and freq_out = eng_freq, then go to OUT.
- REQ-031: In WAIT with eng_done low, the timer SHALL increment. When the timer equals TIMEOUT, the block SHALL:
  - set err_timeout;
  - set raise_data = 0 and freq_out = eng_freq;
  - go to OUT.
- REQ-032: If eng_done is high in the same cycle the timeout is reached, the done path SHALL win and err_timeout SHALL not set.
- REQ-033: In OUT, raise_valid SHALL be high for one cycle, then the FSM returns to IDLE.
  - If freq_out == 63, raise_fin SHALL be high in that cycle and frame_cnt SHALL increment, wrapping 255 -> 0.
- REQ-034: eng_done outside WAIT SHALL be ignored.
- REQ-035: The minimum latency SHALL be fixed:
  - push at edge t gives eng_start in cycle t+2;
  - eng_done in cycle w gives raise_valid in cycle w+1;
  - one job is in flight at a time.
- REQ-036: raise_data and freq_out SHALL hold their values between raise_valid pulses.

Reset
- REQ-037: While rst is low, the block SHALL:
  - set state to IDLE and empty the FIFO (fft_ready = 1);
  - drive eng_start, raise_valid and raise_fin to 0;
  - clear eng_data1/2, eng_freq, raise_data, freq_out, frame_cnt, the timer and both error flags to 0.
- REQ-038: Reset asserted mid-job SHALL abandon the job without any raise_valid pulse; the first cycle after release SHALL be IDLE.

Verification
- REQ-039: Single pair (0x00100020, 0x00300040, freq 5), eng_done 3 cycles after eng_start with result 0x12345678 -> eng_start 2 cycles after push; raise_valid 1 cycle after done with data 0x12345678 and freq_out 5; raise_fin 0.
- REQ-040: 64 pairs, freq 0..63 back-to-back, engine done after 1 cycle -> 64 raise_valid pulses in order; raise_fin only on freq 63; frame_cnt = 1; fft_ready deasserts after DEPTH queued pairs.
- REQ-041: Engine never responds -> err_timeout set after TIMEOUT cycles in WAIT; raise_valid with data 0; the next queued pair is still issued.
- REQ-042: Push with freq1=7, freq2=8 -> err_mismatch = 1 (sticky); job issued with eng_freq = 7; only fft1_valid high -> no push.
- REQ-043: Reset pulse during WAIT with 2 entries queued -> no raise_valid; fft_ready = 1; FIFO empty; all outputs 0 after release.
- REQ-044: 256 full frames -> frame_cnt wraps to 0; eng_done coincident with the timeout edge -> result accepted and err_timeout stays 0.
